// File: rtl/fsm_serial_sequencer_pkg.sv
// Shared definitions for the serial sequencer and anything that models the
// one-bit Mealy recogniser it drives.
//   seq_state_t : sequencer FSM encoding (IDLE, SHIFT, DONE)
//   S_A/S_B/S_C : recogniser state constants; S_A is the state the recogniser
//                 enters whenever its clear input is high at a clock edge.
package fsm_seq_defs;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } seq_state_t;

  localparam logic [1:0] S_A = 2'd0;
  localparam logic [1:0] S_B = 2'd1;
  localparam logic [1:0] S_C = 2'd2;

endpackage

// File: rtl/fsm_serial_sequencer.sv
// Word-level front end for a one-bit Mealy recogniser FSM.
// A WIDTH-bit word taken over in_valid/in_ready is applied LSB-first to the
// recogniser's input a, one bit per clock. The recogniser's x output is
// captured for every bit into a WIDTH-bit result, offered over
// out_valid/out_ready. Between words the recogniser is held in clear, so every
// word is processed starting from S_A.
//
// Ports:
//   clock      rising-edge clock, shared with the recogniser
//   clear_n    asynchronous active-low reset
//   in_valid   input word valid
//   in_ready   sequencer can take a word this cycle
//   in_data    word to serialise; bit 0 is applied first
//   abort      synchronous abort of the word in flight or held in DONE
//   out_valid  result word valid
//   out_ready  consumer takes the result this cycle
//   out_data   result; bit i = recogniser x while in_data bit i was applied
//   fsm_a      to recogniser input a
//   fsm_clear  to recogniser clear (synchronous, active-high at the recogniser)
//   fsm_x      from recogniser output x (combinational Mealy output)
//   busy       high whenever the sequencer is not IDLE
//   words_done count of completed out handshakes, wraps modulo 2^CNT_W
//   dbg_state  current sequencer state
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both high. Valid, once raised by the sequencer, stays high with stable
// data until the transfer (or an abort). A high abort suppresses both the
// input and the output transfer on that edge.
module fsm_serial_sequencer
  import fsm_seq_defs::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             fsm_a,
  output logic             fsm_clear,
  input  logic             fsm_x,
  output logic             busy,
  output logic [CNT_W-1:0] words_done,
  output seq_state_t       dbg_state
);

  localparam int                  CNT_BITS = $clog2(WIDTH);
  localparam logic [CNT_BITS-1:0] LAST_BIT = CNT_BITS'(WIDTH - 1);

  seq_state_t          state;
  seq_state_t          state_d;
  logic [WIDTH-1:0]    shreg;
  logic [WIDTH-1:0]    out_sr;
  logic [CNT_BITS-1:0] cnt;
  logic                accept;
  logic                out_hs;

  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept    = in_valid && in_ready && !abort;
  assign out_hs    = (state == DONE) && out_ready && !abort;
  assign out_valid = (state == DONE);
  assign out_data  = out_sr;
  assign fsm_a     = (state == SHIFT) && shreg[0];
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  // Next-state logic.
  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (accept) state_d = SHIFT;
      end
      SHIFT: begin
        if (abort)                state_d = IDLE;
        else if (cnt == LAST_BIT) state_d = DONE;
      end
      DONE: begin
        if (abort)          state_d = IDLE;
        else if (accept)    state_d = SHIFT;
        else if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state      <= IDLE;
      fsm_clear  <= 1'b1;
      shreg      <= '0;
      out_sr     <= '0;
      cnt        <= '0;
      words_done <= '0;
    end else begin
      state <= state_d;
      // Registered from the next state: the recogniser sees clear for the
      // whole accept cycle (IDLE or DONE), so it sits in S_A for bit 0.
      fsm_clear <= (state_d != SHIFT);
      if (accept) begin
        shreg <= in_data;
        cnt   <= '0;
      end else if (state == SHIFT) begin
        shreg  <= shreg >> 1;
        cnt    <= cnt + CNT_BITS'(1);
        // x enters at the top; after WIDTH shifts the first bit's x is bit 0.
        out_sr <= {fsm_x, out_sr[WIDTH-1:1]};
      end
      if (out_hs) words_done <= words_done + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fsm_serial_sequencer.sv
module tb_fsm_serial_sequencer;
  import fsm_seq_defs::*;

  localparam int WIDTH = 8;
  localparam int CNT_W = 16;

  // ---------------------------------------------------------------- clock/reset
  logic clock = 1'b0;
  logic clear_n = 1'b0;
  always #5 clock = ~clock;

  logic             in_valid = 1'b0;
  logic             abort = 1'b0;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             fsm_a;
  logic             fsm_clear;
  logic             fsm_x;
  logic             busy;
  logic [CNT_W-1:0] words_done;
  seq_state_t       dbg_state;

  fsm_serial_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clock      (clock),
    .clear_n    (clear_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .abort      (abort),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .fsm_a      (fsm_a),
    .fsm_clear  (fsm_clear),
    .fsm_x      (fsm_x),
    .busy       (busy),
    .words_done (words_done),
    .dbg_state  (dbg_state)
  );

  // Recogniser that sits beside the sequencer in the parent.
  logic [1:0] fsm_st = S_A;
  always @(posedge clock) begin
    if (fsm_clear) fsm_st <= S_A;
    else begin
      case (fsm_st)
        S_A:     fsm_st <= fsm_a ? S_C : S_B;
        S_B:     fsm_st <= fsm_a ? S_C : S_A;
        default: fsm_st <= fsm_a ? S_A : S_C;
      endcase
    end
  end
  always_comb begin
    case (fsm_st)
      S_A:     fsm_x = ~fsm_a;
      S_B:     fsm_x = 1'b0;
      default: fsm_x = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------- scoreboard
  int               vectors = 0;
  int               miscompares = 0;
  logic [CNT_W-1:0] exp_done = '0;
  logic [WIDTH-1:0] exp_q[$];

  // Reference: walk the word through a transition/output table from S_A.
  function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] d);
    int               nxt[3][2];
    bit               xo[3][2];
    int               s;
    logic [WIDTH-1:0] r;
    nxt = '{'{1, 2}, '{0, 2}, '{2, 0}};
    xo  = '{'{1'b1, 1'b0}, '{1'b0, 1'b0}, '{1'b1, 1'b1}};
    s = 0;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      r[i] = xo[s][d[i]];
      s    = nxt[s][d[i]];
    end
    return r;
  endfunction

  // ---------------------------------------------------------------- drivers
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Offers one word from IDLE, then waits (bounded) for out_valid.
  // lat = edges from the accept edge to out_valid; a_seen = fsm_a per bit.
  task automatic feed(input logic [WIDTH-1:0] d, output int lat,
                      output logic [WIDTH-1:0] a_seen, output logic clr_seen);
    in_data  = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_data  = WIDTH'($urandom);
    lat      = 0;
    a_seen   = '0;
    clr_seen = 1'b0;
    while (!out_valid && lat < 40) begin
      if (lat < WIDTH) a_seen[lat] = fsm_a;
      clr_seen = clr_seen | fsm_clear;
      tick();
      lat++;
    end
  endtask

  task automatic take();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp_done  = exp_done + 1'b1;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    clear_n  = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h3C;
    repeat (3) @(posedge clock);
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (dbg_state !== IDLE) begin miscompares++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    vectors++; if (out_data !== 8'h00) begin miscompares++; $display("FAIL reset_out_data: got %h want 00", out_data); end
    vectors++; if (fsm_clear !== 1'b1) begin miscompares++; $display("FAIL reset_fsm_clear: got %b want 1", fsm_clear); end
    vectors++; if (fsm_a !== 1'b0) begin miscompares++; $display("FAIL reset_fsm_a: got %b want 0", fsm_a); end
    vectors++; if (words_done !== 16'd0) begin miscompares++; $display("FAIL reset_words_done: got %0d want 0", words_done); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    in_valid = 1'b0;
    clear_n  = 1'b1;
    exp_done = '0;
    tick();
  endtask

  task automatic test_directed();
    logic [WIDTH-1:0] din[3];
    logic [WIDTH-1:0] want[3];
    logic [WIDTH-1:0] a_seen;
    logic             clr_seen;
    int               lat;
    din  = '{8'h00, 8'hFF, 8'h01};
    want = '{8'h55, 8'hAA, 8'hFE};
    for (int i = 0; i < 3; i++) begin
      feed(din[i], lat, a_seen, clr_seen);
      vectors++; if (lat !== WIDTH) begin miscompares++; $display("FAIL dir_latency[%0d]: got %0d want %0d", i, lat, WIDTH); end
      vectors++; if (out_data !== want[i]) begin miscompares++; $display("FAIL dir_out_data[%0d]: got %h want %h", i, out_data, want[i]); end
      vectors++; if (a_seen !== din[i]) begin miscompares++; $display("FAIL dir_fsm_a_bits[%0d]: got %h want %h", i, a_seen, din[i]); end
      vectors++; if (clr_seen !== 1'b0) begin miscompares++; $display("FAIL dir_clear_in_shift[%0d]: got %b want 0", i, clr_seen); end
      vectors++; if (fsm_clear !== 1'b1) begin miscompares++; $display("FAIL dir_clear_in_done[%0d]: got %b want 1", i, fsm_clear); end
      take();
      vectors++; if (words_done !== exp_done) begin miscompares++; $display("FAIL dir_words_done[%0d]: got %0d want %0d", i, words_done, exp_done); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL dir_idle_after[%0d]: got %b want 0", i, busy); end
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    out_ready = 1'b1;
    in_data   = 8'h00;
    in_valid  = 1'b1;
    tick();
    in_data = 8'hFF;   // next word; must not disturb the one in flight
    lat = 0;
    while (!out_valid && lat < 40) begin tick(); lat++; end
    vectors++; if (lat !== WIDTH) begin miscompares++; $display("FAIL b2b_latency0: got %0d want %0d", lat, WIDTH); end
    vectors++; if (out_data !== 8'h55) begin miscompares++; $display("FAIL b2b_word0: got %h want 55", out_data); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_in_ready_done: got %b want 1", in_ready); end
    tick();
    exp_done = exp_done + 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h5A;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_single_done: got %b want 0", out_valid); end
    vectors++; if (dbg_state !== SHIFT) begin miscompares++; $display("FAIL b2b_direct_shift: got %0d want 1", dbg_state); end
    vectors++; if (fsm_clear !== 1'b0) begin miscompares++; $display("FAIL b2b_clear_low: got %b want 0", fsm_clear); end
    vectors++; if (words_done !== exp_done) begin miscompares++; $display("FAIL b2b_words_done0: got %0d want %0d", words_done, exp_done); end
    lat = 0;
    while (!out_valid && lat < 40) begin tick(); lat++; end
    vectors++; if (lat !== WIDTH) begin miscompares++; $display("FAIL b2b_latency1: got %0d want %0d", lat, WIDTH); end
    vectors++; if (out_data !== 8'hAA) begin miscompares++; $display("FAIL b2b_word1: got %h want AA", out_data); end
    tick();
    exp_done  = exp_done + 1'b1;
    out_ready = 1'b0;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL b2b_idle_after: got %b want 0", busy); end
    vectors++; if (words_done !== exp_done) begin miscompares++; $display("FAIL b2b_words_done1: got %0d want %0d", words_done, exp_done); end
  endtask

  task automatic test_stall();
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] want;
    logic [WIDTH-1:0] a_seen;
    logic             clr_seen;
    int               lat;
    d    = WIDTH'($urandom);
    want = model(d);
    feed(d, lat, a_seen, clr_seen);
    vectors++; if (lat !== WIDTH) begin miscompares++; $display("FAIL stall_latency: got %0d want %0d", lat, WIDTH); end
    in_valid = 1'b1;   // a waiting word must not be taken while out_ready is low
    for (int c = 0; c < 5; c++) begin
      in_data = WIDTH'($urandom);
      #1;
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL stall_out_valid[%0d]: got %b want 1", c, out_valid); end
      vectors++; if (out_data !== want) begin miscompares++; $display("FAIL stall_out_data[%0d]: got %h want %h", c, out_data, want); end
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL stall_in_ready[%0d]: got %b want 0", c, in_ready); end
      vectors++; if (fsm_clear !== 1'b1) begin miscompares++; $display("FAIL stall_fsm_clear[%0d]: got %b want 1", c, fsm_clear); end
      vectors++; if (fsm_a !== 1'b0) begin miscompares++; $display("FAIL stall_fsm_a[%0d]: got %b want 0", c, fsm_a); end
      tick();
    end
    in_valid = 1'b0;
    take();
    vectors++; if (words_done !== exp_done) begin miscompares++; $display("FAIL stall_words_done: got %0d want %0d", words_done, exp_done); end
  endtask

  task automatic test_abort();
    logic [WIDTH-1:0] a_seen;
    logic             clr_seen;
    logic             seen_valid;
    int               lat;
    // Abort while bit 3 is on fsm_a.
    in_data  = 8'h00;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    vectors++; if (dbg_state !== IDLE) begin miscompares++; $display("FAIL abort_shift_state: got %0d want 0", dbg_state); end
    vectors++; if (fsm_clear !== 1'b1) begin miscompares++; $display("FAIL abort_shift_clear: got %b want 1", fsm_clear); end
    seen_valid = 1'b0;
    repeat (12) begin seen_valid = seen_valid | out_valid; tick(); end
    vectors++; if (seen_valid !== 1'b0) begin miscompares++; $display("FAIL abort_shift_no_result: got %b want 0", seen_valid); end
    vectors++; if (words_done !== exp_done) begin miscompares++; $display("FAIL abort_shift_words_done: got %0d want %0d", words_done, exp_done); end
    feed(8'h00, lat, a_seen, clr_seen);
    vectors++; if (out_data !== 8'h55) begin miscompares++; $display("FAIL abort_next_word: got %h want 55", out_data); end
    take();
    vectors++; if (words_done !== exp_done) begin miscompares++; $display("FAIL abort_next_words_done: got %0d want %0d", words_done, exp_done); end
    // Abort in DONE beats both the out handshake and a new word.
    feed(WIDTH'($urandom), lat, a_seen, clr_seen);
    abort     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    tick();
    abort     = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    vectors++; if (dbg_state !== IDLE) begin miscompares++; $display("FAIL abort_done_state: got %0d want 0", dbg_state); end
    vectors++; if (words_done !== exp_done) begin miscompares++; $display("FAIL abort_done_words_done: got %0d want %0d", words_done, exp_done); end
    // Abort in IDLE blocks a simultaneous offer.
    abort    = 1'b1;
    in_valid = 1'b1;
    tick();
    abort    = 1'b0;
    in_valid = 1'b0;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_idle_no_accept: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    logic [WIDTH-1:0] a_seen;
    logic             clr_seen;
    int               lat;
    in_data  = WIDTH'($urandom);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    clear_n = 1'b0;
    #1;
    exp_done = '0;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rmid_busy: got %b want 0", busy); end
    vectors++; if (out_data !== 8'h00) begin miscompares++; $display("FAIL rmid_out_data: got %h want 00", out_data); end
    vectors++; if (fsm_clear !== 1'b1) begin miscompares++; $display("FAIL rmid_fsm_clear: got %b want 1", fsm_clear); end
    vectors++; if (fsm_a !== 1'b0) begin miscompares++; $display("FAIL rmid_fsm_a: got %b want 0", fsm_a); end
    vectors++; if (words_done !== exp_done) begin miscompares++; $display("FAIL rmid_words_done: got %0d want 0", words_done); end
    repeat (2) tick();
    clear_n = 1'b1;
    tick();
    feed(8'h01, lat, a_seen, clr_seen);
    vectors++; if (lat !== WIDTH) begin miscompares++; $display("FAIL rmid_latency: got %0d want %0d", lat, WIDTH); end
    vectors++; if (out_data !== 8'hFE) begin miscompares++; $display("FAIL rmid_word: got %h want FE", out_data); end
    take();
    vectors++; if (words_done !== exp_done) begin miscompares++; $display("FAIL rmid_words_after: got %0d want %0d", words_done, exp_done); end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] want;
    logic [WIDTH-1:0] a_seen;
    logic             clr_seen;
    int               lat;
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 3)) tick();
      d = WIDTH'($urandom);
      exp_q.push_back(model(d));
      feed(d, lat, a_seen, clr_seen);
      vectors++; if (lat !== WIDTH) begin miscompares++; $display("FAIL rnd_latency[%0d]: got %0d want %0d", n, lat, WIDTH); end
      vectors++; if (a_seen !== d) begin miscompares++; $display("FAIL rnd_fsm_a_bits[%0d]: got %h want %h", n, a_seen, d); end
      repeat ($urandom_range(0, 3)) tick();
      want = exp_q.pop_front();
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL rnd_out_valid[%0d]: got %b want 1", n, out_valid); end
      vectors++; if (out_data !== want) begin miscompares++; $display("FAIL rnd_out_data[%0d]: in %h got %h want %h", n, d, out_data, want); end
      take();
      vectors++; if (words_done !== exp_done) begin miscompares++; $display("FAIL rnd_words_done[%0d]: got %0d want %0d", n, words_done, exp_done); end
    end
  endtask

  // ---------------------------------------------------------------- sequence + report
  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_abort();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
